// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Writer side of the instruction memory. Receives a byte
//               stream (count_hi, count_lo, 4*count big-endian data bytes,
//               XOR checksum byte), writes each assembled 32-bit word to
//               consecutive word addresses from BASE_ADDRESS, and releases
//               the processor from reset once the checksum matches.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous active-high reset
//   byte_valid_i  in   1  source presents a byte
//   byte_data_i   in   8  stream byte
//   byte_ready_o  out  1  loader accepts a byte this cycle
//   imem_we_o     out  1  one-cycle program-memory write strobe
//   imem_addr_o   out 32  byte address of the word being written
//   imem_wdata_o  out 32  instruction word being written
//   core_reset_o  out  1  active-high processor reset
//   done_o        out  1  load completed, checksum OK
//   error_o       out  1  load aborted
// Optional feature macro: BOOT_LOADER_TIMEOUT_EN
//   When defined, an inter-byte timeout of TIMEOUT_CYCLES clocks in the
//   LEN_LO, DATA and CHECK states sends the loader to ERROR.
// ============================================================================
module boot_loader #(
  parameter int          MEMORY_DEPTH   = 32,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Widened by one bit so a 16-bit count of 0xFFFF compares correctly.
  localparam logic [16:0] MAX_COUNT = 17'(MEMORY_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  lane_q,  lane_d;
  logic [31:0] word_q,  word_d;
  logic [7:0]  csum_q,  csum_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic accept;

  assign byte_ready_o = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept       = byte_valid_i && byte_ready_o;

  assign imem_we_o    = (state_q == S_WRITE);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERROR);
  assign core_reset_o = (state_q != S_DONE);

`ifdef BOOT_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             timed;
  logic             tmo_hit;

  // LEN_HI is deliberately excluded: the loader waits forever for a stream.
  assign timed   = (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                   (state_q == S_CHECK);
  assign tmo_hit = timed && !accept &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Any cycle outside the timed states (notably WRITE) clears the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (!timed || accept) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    lane_d  = lane_q;
    word_d  = word_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          count_d = {byte_data_i, 8'h00};
          state_d = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          count_d = {count_q[15:8], byte_data_i};
          if ({1'b0, count_d} > MAX_COUNT) begin
            state_d = S_ERROR;
          end else if (count_d == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], byte_data_i};
          csum_d = csum_q ^ byte_data_i;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Address and data are latched here so they are stable for the
            // whole WRITE cycle and then hold until the next word.
            addr_d  = BASE_ADDRESS + {14'd0, index_q, 2'b00};
            wdata_d = word_d;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        index_d = index_q + 16'd1;
        lane_d  = 2'd0;
        state_d = (index_d == count_q) ? S_CHECK : S_DATA;
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (byte_data_i == csum_q) ? S_DONE : S_ERROR;
        end
      end

      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

`ifdef BOOT_LOADER_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = S_ERROR;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      count_q <= '0;
      index_q <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      addr_q  <= BASE_ADDRESS;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
`default_nettype wire
